// File: rtl/rsa_cmd_responder.sv
// ARM command/data protocol responder for the RSA wrapper.
// Decodes commands, moves operands to the core, starts the core and returns its result.
module rsa_cmd_responder #(
    parameter int DATA_W = 1024,
    parameter int CMD_W  = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [CMD_W-1:0]  arm_to_fpga_cmd,
    input  logic              arm_to_fpga_cmd_valid,
    output logic              fpga_to_arm_done,
    input  logic              fpga_to_arm_done_read,
    input  logic              arm_to_fpga_data_valid,
    output logic              arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0] arm_to_fpga_data,
    output logic              fpga_to_arm_data_valid,
    input  logic              fpga_to_arm_data_ready,
    output logic [DATA_W-1:0] fpga_to_arm_data,
    output logic              load_en,
    output logic [OP_W-1:0]   load_sel,
    output logic [DATA_W-1:0] load_data,
    output logic              core_start,
    output logic              core_op,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              cmd_error,
    output logic [3:0]        leds
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RX    = 4'd1,
        S_START = 4'd2,
        S_BUSY  = 4'd3,
        S_TX    = 4'd4,
        S_DONE  = 4'd5
    } state_t;

    localparam logic [CMD_W-1:0] CMD_READ_EXP      = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_READ_A_B      = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_READ_M        = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_COMPUTE_EXP   = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_COMPUTE_MONT  = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_READ_MOD_RMOD = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_READ_RSQ      = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_READ_X        = CMD_W'(7);
    localparam logic [CMD_W-1:0] CMD_WRITE         = CMD_W'(8);

    state_t             state_reg,     state_next;
    logic               load_en_reg,   load_en_next;
    logic [OP_W-1:0]    load_sel_reg,  load_sel_next;
    logic [DATA_W-1:0]  load_data_reg, load_data_next;
    logic               op_reg,        op_next;
    logic [DATA_W-1:0]  result_reg,    result_next;
    logic               cmd_error_reg, cmd_error_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= S_IDLE;
            load_en_reg   <= 1'b0;
            load_sel_reg  <= '0;
            load_data_reg <= '0;
            op_reg        <= 1'b0;
            result_reg    <= '0;
            cmd_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            load_en_reg   <= load_en_next;
            load_sel_reg  <= load_sel_next;
            load_data_reg <= load_data_next;
            op_reg        <= op_next;
            result_reg    <= result_next;
            cmd_error_reg <= cmd_error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_en_next   = 1'b0;
        load_sel_next  = load_sel_reg;
        load_data_next = load_data_reg;
        op_next        = op_reg;
        result_next    = result_reg;
        cmd_error_next = cmd_error_reg;

        case (state_reg)
            S_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    cmd_error_next = 1'b0;
                    state_next     = S_RX;
                    case (arm_to_fpga_cmd)
                        CMD_READ_EXP:      load_sel_next = OP_W'(0);
                        CMD_READ_A_B:      load_sel_next = OP_W'(1);
                        CMD_READ_M:        load_sel_next = OP_W'(2);
                        CMD_READ_MOD_RMOD: load_sel_next = OP_W'(3);
                        CMD_READ_RSQ:      load_sel_next = OP_W'(4);
                        CMD_READ_X:        load_sel_next = OP_W'(5);
                        CMD_COMPUTE_MONT: begin
                            op_next    = 1'b0;
                            state_next = S_START;
                        end
                        CMD_COMPUTE_EXP: begin
                            op_next    = 1'b1;
                            state_next = S_START;
                        end
                        CMD_WRITE: state_next = S_TX;
                        default: begin
                            cmd_error_next = 1'b1;
                            state_next     = S_DONE;
                        end
                    endcase
                end
            end
            S_RX: begin
                // Stay in RX for the strobe cycle so the operand write lands before done.
                if (load_en_reg) begin
                    state_next = S_DONE;
                end else if (arm_to_fpga_data_valid) begin
                    load_en_next   = 1'b1;
                    load_data_next = arm_to_fpga_data;
                end
            end
            S_START: state_next = S_BUSY;
            S_BUSY: begin
                if (core_done) begin
                    result_next = core_result;
                    state_next  = S_DONE;
                end
            end
            S_TX: begin
                if (fpga_to_arm_data_ready) state_next = S_DONE;
            end
            S_DONE: begin
                if (fpga_to_arm_done_read) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign arm_to_fpga_data_ready = (state_reg == S_RX) && !load_en_reg;
    assign fpga_to_arm_data_valid = (state_reg == S_TX);
    assign fpga_to_arm_done       = (state_reg == S_DONE);
    assign fpga_to_arm_data       = result_reg;
    assign load_en                = load_en_reg;
    assign load_sel               = load_sel_reg;
    assign load_data              = load_data_reg;
    assign core_start             = (state_reg == S_START);
    assign core_op                = core_start & op_reg;
    assign cmd_error              = cmd_error_reg;
    assign leds                   = state_reg;

endmodule

// File: tb/tb_rsa_cmd_responder.sv
// Directed bench for rsa_cmd_responder: operand loads, compute, result readback,
// unknown commands, reset abort and done_read/cmd_valid collision.
module tb_rsa_cmd_responder;
    localparam int DATA_W = 1024;
    localparam int CMD_W  = 32;
    localparam int OP_W   = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic [CMD_W-1:0]  arm_to_fpga_cmd;
    logic              arm_to_fpga_cmd_valid;
    logic              fpga_to_arm_done;
    logic              fpga_to_arm_done_read;
    logic              arm_to_fpga_data_valid;
    logic              arm_to_fpga_data_ready;
    logic [DATA_W-1:0] arm_to_fpga_data;
    logic              fpga_to_arm_data_valid;
    logic              fpga_to_arm_data_ready;
    logic [DATA_W-1:0] fpga_to_arm_data;
    logic              load_en;
    logic [OP_W-1:0]   load_sel;
    logic [DATA_W-1:0] load_data;
    logic              core_start;
    logic              core_op;
    logic              core_done;
    logic [DATA_W-1:0] core_result;
    logic              cmd_error;
    logic [3:0]        leds;

    int checks = 0;
    int errors = 0;

    rsa_cmd_responder #(.DATA_W(DATA_W), .CMD_W(CMD_W), .OP_W(OP_W)) dut (
        .clk(clk), .resetn(resetn),
        .arm_to_fpga_cmd(arm_to_fpga_cmd), .arm_to_fpga_cmd_valid(arm_to_fpga_cmd_valid),
        .fpga_to_arm_done(fpga_to_arm_done), .fpga_to_arm_done_read(fpga_to_arm_done_read),
        .arm_to_fpga_data_valid(arm_to_fpga_data_valid), .arm_to_fpga_data_ready(arm_to_fpga_data_ready),
        .arm_to_fpga_data(arm_to_fpga_data),
        .fpga_to_arm_data_valid(fpga_to_arm_data_valid), .fpga_to_arm_data_ready(fpga_to_arm_data_ready),
        .fpga_to_arm_data(fpga_to_arm_data),
        .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
        .core_start(core_start), .core_op(core_op),
        .core_done(core_done), .core_result(core_result),
        .cmd_error(cmd_error), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [CMD_W-1:0] c);
        arm_to_fpga_cmd       = c;
        arm_to_fpga_cmd_valid = 1'b1;
        tick();
        arm_to_fpga_cmd_valid = 1'b0;
    endtask

    task automatic ack_done(input string tag);
        chk({tag, "_done_before_ack"}, DATA_W'(fpga_to_arm_done), DATA_W'(1));
        fpga_to_arm_done_read = 1'b1;
        tick();
        fpga_to_arm_done_read = 1'b0;
        chk({tag, "_done_cleared"}, DATA_W'(fpga_to_arm_done), DATA_W'(0));
        chk({tag, "_leds_idle"}, DATA_W'(leds), DATA_W'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"},   DATA_W'(fpga_to_arm_done), DATA_W'(0));
        chk({tag, "_ready"},  DATA_W'(arm_to_fpga_data_ready), DATA_W'(0));
        chk({tag, "_ovalid"}, DATA_W'(fpga_to_arm_data_valid), DATA_W'(0));
        chk({tag, "_odata"},  fpga_to_arm_data, '0);
        chk({tag, "_load"},   DATA_W'(load_en), DATA_W'(0));
        chk({tag, "_start"},  DATA_W'(core_start), DATA_W'(0));
        chk({tag, "_err"},    DATA_W'(cmd_error), DATA_W'(0));
        chk({tag, "_leds"},   DATA_W'(leds), DATA_W'(0));
    endtask

    logic [DATA_W-1:0] d1, d2;
    int cnt;

    initial begin
        d1 = {32{32'h1288_018d}};
        d2 = {16{64'hDEAD_BEEF_0123_4567}};
        resetn = 1'b0;
        arm_to_fpga_cmd = '0; arm_to_fpga_cmd_valid = 1'b0;
        fpga_to_arm_done_read = 1'b0; arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data = '0; fpga_to_arm_data_ready = 1'b0;
        core_done = 1'b0; core_result = '0;
        #12;
        chk_all_zero("reset");
        tick();
        resetn = 1'b1;
        tick();

        // Cmd 1 with data valid already held; IDLE must ignore it.
        arm_to_fpga_data_valid = 1'b1;
        arm_to_fpga_data = d1;
        chk("idle_ready_low", DATA_W'(arm_to_fpga_data_ready), DATA_W'(0));
        send_cmd(32'd1);
        chk("rx1_leds", DATA_W'(leds), DATA_W'(1));
        chk("rx1_ready", DATA_W'(arm_to_fpga_data_ready), DATA_W'(1));
        chk("rx1_no_load_yet", DATA_W'(load_en), DATA_W'(0));
        tick();
        arm_to_fpga_data_valid = 1'b0;
        chk("rx1_load_en", DATA_W'(load_en), DATA_W'(1));
        chk("rx1_load_sel", DATA_W'(load_sel), DATA_W'(1));
        chk("rx1_load_data", load_data, d1);
        chk("rx1_ready_drop", DATA_W'(arm_to_fpga_data_ready), DATA_W'(0));
        chk("rx1_done_not_yet", DATA_W'(fpga_to_arm_done), DATA_W'(0));
        tick();
        chk("rx1_load_single", DATA_W'(load_en), DATA_W'(0));
        chk("rx1_leds_done", DATA_W'(leds), DATA_W'(5));
        tick(); tick();
        chk("rx1_done_held", DATA_W'(fpga_to_arm_done), DATA_W'(1));
        ack_done("rx1");

        // Cmd 2 with data valid delayed 20 cycles.
        send_cmd(32'd2);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!arm_to_fpga_data_ready || load_en) cnt++;
            tick();
        end
        chk("rx2_wait_ready_no_load", DATA_W'(cnt), DATA_W'(0));
        arm_to_fpga_data_valid = 1'b1;
        arm_to_fpga_data = d2;
        tick();
        arm_to_fpga_data_valid = 1'b0;
        chk("rx2_load_en", DATA_W'(load_en), DATA_W'(1));
        chk("rx2_load_sel", DATA_W'(load_sel), DATA_W'(2));
        chk("rx2_load_data", load_data, d2);
        chk("rx2_cmd_error", DATA_W'(cmd_error), DATA_W'(0));
        tick();
        ack_done("rx2");

        // Cmd 4: Montgomery multiply, core_done 50 cycles later.
        send_cmd(32'd4);
        chk("mont_start", DATA_W'(core_start), DATA_W'(1));
        chk("mont_op", DATA_W'(core_op), DATA_W'(0));
        chk("mont_leds_start", DATA_W'(leds), DATA_W'(2));
        tick();
        chk("mont_leds_busy", DATA_W'(leds), DATA_W'(3));
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (core_start || fpga_to_arm_done) cnt++;
            tick();
        end
        chk("mont_busy_quiet", DATA_W'(cnt), DATA_W'(0));
        core_done = 1'b1;
        core_result = DATA_W'(32'hABCD);
        chk("mont_done_not_early", DATA_W'(fpga_to_arm_done), DATA_W'(0));
        tick();
        core_done = 1'b0;
        core_result = '0;
        chk("mont_done_after_core", DATA_W'(fpga_to_arm_done), DATA_W'(1));
        ack_done("mont");

        // Cmd 8 with ready delayed 5 cycles.
        send_cmd(32'd8);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (!fpga_to_arm_data_valid || fpga_to_arm_data !== DATA_W'(32'hABCD) || leds !== 4'd4) cnt++;
            tick();
        end
        chk("tx_hold_stable", DATA_W'(cnt), DATA_W'(0));
        fpga_to_arm_data_ready = 1'b1;
        chk("tx_data", fpga_to_arm_data, DATA_W'(32'hABCD));
        tick();
        fpga_to_arm_data_ready = 1'b0;
        chk("tx_valid_drop", DATA_W'(fpga_to_arm_data_valid), DATA_W'(0));
        ack_done("tx");

        // Unknown cmd 0xF, then cmd 3 clears the error.
        send_cmd(32'hF);
        chk("bad_done", DATA_W'(fpga_to_arm_done), DATA_W'(1));
        chk("bad_err", DATA_W'(cmd_error), DATA_W'(1));
        chk("bad_side_effects", DATA_W'({load_en, core_start, fpga_to_arm_data_valid}), DATA_W'(0));
        ack_done("bad");
        chk("bad_err_sticky", DATA_W'(cmd_error), DATA_W'(1));
        send_cmd(32'd3);
        chk("exp_err_clear", DATA_W'(cmd_error), DATA_W'(0));
        chk("exp_start", DATA_W'(core_start), DATA_W'(1));
        chk("exp_op", DATA_W'(core_op), DATA_W'(1));
        tick();
        core_done = 1'b1;
        core_result = DATA_W'(32'h1234);
        tick();
        core_done = 1'b0;
        ack_done("exp");
        chk("exp_result", fpga_to_arm_data, DATA_W'(32'h1234));

        // Reset during BUSY, then a late core_done must be ignored.
        send_cmd(32'd4);
        tick();
        chk("rst_busy_leds", DATA_W'(leds), DATA_W'(3));
        resetn = 1'b0;
        #1;
        chk_all_zero("rst_busy");
        tick();
        resetn = 1'b1;
        core_done = 1'b1;
        core_result = DATA_W'(32'h5555);
        tick();
        core_done = 1'b0;
        chk("late_core_done_leds", DATA_W'(leds), DATA_W'(0));
        chk("late_core_done_data", fpga_to_arm_data, '0);

        // Reset during TX.
        send_cmd(32'd8);
        chk("rst_tx_valid_before", DATA_W'(fpga_to_arm_data_valid), DATA_W'(1));
        resetn = 1'b0;
        #1;
        chk_all_zero("rst_tx");
        tick();
        resetn = 1'b1;
        tick();
        send_cmd(32'd8);
        fpga_to_arm_data_ready = 1'b1;
        chk("post_rst_write_data", fpga_to_arm_data, '0);
        tick();
        fpga_to_arm_data_ready = 1'b0;
        ack_done("post_rst_write");

        // done_read and cmd_valid together: command dropped.
        send_cmd(32'hF);
        arm_to_fpga_cmd = 32'd8;
        arm_to_fpga_cmd_valid = 1'b1;
        fpga_to_arm_done_read = 1'b1;
        tick();
        arm_to_fpga_cmd_valid = 1'b0;
        fpga_to_arm_done_read = 1'b0;
        chk("collide_leds_idle", DATA_W'(leds), DATA_W'(0));
        tick();
        chk("collide_still_idle", DATA_W'(leds), DATA_W'(0));
        chk("collide_no_valid", DATA_W'(fpga_to_arm_data_valid), DATA_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
